// File: rtl/sram_arb_ctrl_pkg.sv
// Shared types and helpers for the SRAM arbiter/controller.
// States, index-width helper and default sizing.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sram_ctrl_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NREQ_DEF = 4;
  localparam int NREQ_W   = idx_w(NREQ_DEF);

endpackage

// File: rtl/sram_arb_ctrl_if.sv
// Requester-side bundle of the SRAM arbiter/controller.
// master = requesters, slave = controller.
interface sram_arb_ctrl_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 4
);
  import sram_ctrl_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               init_done;

  modport master (
    output req_valid, req_we,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, init_done
  );

endinterface

// File: rtl/sram_arb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Priority starts at i_ptr and rotates upward.
module rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  int w_j;

  // Scan lowest priority first so the slot at i_ptr wins last.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_gnt_idx  = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Round-robin shared access to a single-port SRAM macro,
// with zero-fill after reset and fixed read latency.
module sram_arb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 4,
  parameter  int RD_LAT     = 2,
  localparam int IW         = idx_w(NREQ),
  localparam int WW         = idx_w(RD_LAT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sram_arb_ctrl_if.slave        bus,
  output logic                  o_sram_we,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_din,
  input  logic [DATA_WIDTH-1:0] i_sram_dout
);

  sram_ctrl_state_e r_state, w_state_n;

  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_n;
  logic [WW-1:0]         r_wait, w_wait_n;
  logic [IW-1:0]         r_ptr, w_ptr_n;
  logic [IW-1:0]         r_g, w_g_n;
  logic                  r_we, w_we_n;
  logic                  r_sram_we, w_sram_we_n;
  logic [ADDR_WIDTH-1:0] r_sram_addr, w_sram_addr_n;
  logic [DATA_WIDTH-1:0] r_sram_din, w_sram_din_n;
  logic [NREQ-1:0]       r_rsp_valid, w_rsp_valid_n;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_n;
  logic                  r_init_done, w_init_done_n;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gidx;
  logic            w_any;
  logic            w_sel_we;

  rr_arbiter #(.N(NREQ)) u_arb (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gidx)
  );

  assign w_any    = |bus.req_valid;
  assign w_sel_we = bus.req_we[w_gidx];

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_wait_n      = r_wait;
    w_ptr_n       = r_ptr;
    w_g_n         = r_g;
    w_we_n        = r_we;
    w_sram_we_n   = 1'b0;
    w_sram_addr_n = r_sram_addr;
    w_sram_din_n  = r_sram_din;
    w_rsp_valid_n = '0;
    w_rsp_rdata_n = r_rsp_rdata;
    w_init_done_n = r_init_done;
    case (r_state)
      INIT: begin
        w_sram_we_n   = 1'b1;
        w_sram_addr_n = r_cnt;
        w_sram_din_n  = '0;
        w_cnt_n       = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_init_done_n = 1'b1;
          w_state_n     = IDLE;
        end
      end
      IDLE: begin
        if (w_any) begin
          w_g_n         = w_gidx;
          w_we_n        = w_sel_we;
          w_sram_we_n   = w_sel_we;
          w_sram_addr_n = bus.req_addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
          // Read data slices may be junk; keep din stable on reads.
          if (w_sel_we)
            w_sram_din_n = bus.req_wdata[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
          w_ptr_n   = (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
          w_state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (r_we) begin
          w_rsp_rdata_n = '0;
          w_state_n     = RESP;
        end else begin
          w_wait_n  = WW'(RD_LAT - 1);
          w_state_n = WAIT;
        end
      end
      WAIT: begin
        if (r_wait == '0) begin
          w_rsp_rdata_n = i_sram_dout;
          w_state_n     = RESP;
        end else begin
          w_wait_n = r_wait - 1'b1;
        end
      end
      RESP: begin
        w_rsp_valid_n[r_g] = 1'b1;
        w_state_n          = IDLE;
      end
      default: w_state_n = INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_ptr       <= '0;
      r_g         <= '0;
      r_we        <= 1'b0;
      r_sram_we   <= 1'b0;
      r_sram_addr <= '0;
      r_sram_din  <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_wait      <= w_wait_n;
      r_ptr       <= w_ptr_n;
      r_g         <= w_g_n;
      r_we        <= w_we_n;
      r_sram_we   <= w_sram_we_n;
      r_sram_addr <= w_sram_addr_n;
      r_sram_din  <= w_sram_din_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_rdata <= w_rsp_rdata_n;
      r_init_done <= w_init_done_n;
    end
  end

  assign bus.req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.init_done = r_init_done;
  assign o_sram_we     = r_sram_we;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_din    = r_sram_din;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench for sram_arb_ctrl with a behavioural
// read-first SRAM (T_RD = 5ns) and a reference memory model.
module tb_sram_arb_ctrl;

  localparam int NREQ   = 4;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << AW;
  localparam int QD     = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arb_ctrl_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;

  sram_arb_ctrl #(
    .NREQ(NREQ), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_sram_we   (sram_we),
    .o_sram_addr (sram_addr),
    .o_sram_din  (sram_din),
    .i_sram_dout (sram_dout)
  );

  // SRAM macro: read-first, dout settles 5ns after the edge.
  logic [DW-1:0] smem[DEPTH];
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;

  initial begin
    for (int a = 0; a < DEPTH; a++) smem[a] = 8'($urandom_range(1, 255));
    s_we = 1'b0; s_addr = '0; s_din = '0;
    forever begin
      @(negedge clk);
      s_we = sram_we; s_addr = sram_addr; s_din = sram_din;
    end
  end

  initial begin
    forever begin
      logic [DW-1:0] rd;
      @(posedge clk);
      rd = smem[s_addr];
      if (s_we) smem[s_addr] = s_din;
      #5 sram_dout = rd;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int hs_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input int v);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: value %0d (cycle %0d)", nm, v, cyc);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    int            r;
    logic [DW-1:0] rd;
    int            due;
  } exp_t;

  txn_t tq[NREQ][QD];
  int   hd[NREQ] = '{default: 0};
  int   tl[NREQ] = '{default: 0};
  bit   hs_flag[NREQ] = '{default: 0};
  bit   pulse_req[NREQ] = '{default: 0};
  bit   pulse_act[NREQ] = '{default: 0};
  txn_t pulse_txn[NREQ];

  exp_t          sbq[$];
  int            gseq[$];
  logic [DW-1:0] mmem[DEPTH];
  int            mptr = 0;

  task automatic push(input int r, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    tq[r][tl[r] % QD] = '{we: we, addr: a, data: d};
    tl[r]++;
  endtask

  task automatic present(input int i, input txn_t t);
    bus.req_valid[i]            = 1'b1;
    bus.req_we[i]               = t.we;
    bus.req_addr[i*AW +: AW]    = t.addr;
    bus.req_wdata[i*DW +: DW]   = t.data;
  endtask

  // Requester driver: holds each request valid until granted.
  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_flag[i]) begin
          hs_flag[i] = 1'b0;
          if (!pulse_act[i]) hd[i]++;
          bus.req_valid[i] = 1'b0;
        end
        if (pulse_act[i]) begin
          pulse_act[i]     = 1'b0;
          bus.req_valid[i] = 1'b0;
        end
        if (pulse_req[i]) begin
          pulse_req[i] = 1'b0;
          pulse_act[i] = 1'b1;
          present(i, pulse_txn[i]);
        end else if (!bus.req_valid[i] && hd[i] != tl[i]) begin
          present(i, tq[i][hd[i] % QD]);
        end
        if (!bus.req_valid[i]) begin
          bus.req_we[i]             = 1'($urandom);
          bus.req_addr[i*AW +: AW]  = AW'($urandom);
          bus.req_wdata[i*DW +: DW] = DW'($urandom);
        end
      end
    end
  end

  // Handshake monitor: checks the grant against round-robin
  // order and pushes the expected response.
  task automatic hs_step();
    logic [NREQ-1:0] v, rd;
    int w, g, j;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    v = bus.req_valid;
    rd = bus.req_ready;
    w = -1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (mptr + k) % NREQ;
      if (v[j] && w < 0) w = j;
    end
    chk("grant", 32'(rd), (w < 0) ? 32'd0 : (32'd1 << w));
    for (int i = 0; i < NREQ; i++) if (rd[i] && v[i]) g = i;
    if (g < 0) return;
    if (pulse_act[g]) fail_now("pulse_grant", g);
    hs_flag[g] = 1'b1;
    hs_cnt++;
    gseq.push_back(g);
    if (w < 0) return;
    we = bus.req_we[w];
    a  = bus.req_addr[w*AW +: AW];
    d  = bus.req_wdata[w*DW +: DW];
    mptr = (w + 1) % NREQ;
    if (we) begin
      mmem[a] = d;
      sbq.push_back('{r: w, rd: '0, due: cyc + 1 + 2});
    end else begin
      sbq.push_back('{r: w, rd: mmem[a], due: cyc + 1 + 2 + RD_LAT});
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && bus.req_ready != '0) hs_step();
  end

  // Response monitor.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.rsp_valid != '0) begin
      if (sbq.size() == 0) begin
        fail_now("unexpected_rsp", int'(bus.rsp_valid));
      end else begin
        e = sbq.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << e.r);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rd));
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
      fail_now("rsp_timeout", sbq[0].r);
      void'(sbq.pop_front());
    end
  end

  function automatic bit busy();
    for (int i = 0; i < NREQ; i++)
      if (hd[i] != tl[i] || bus.req_valid[i] || pulse_req[i]) return 1'b1;
    return sbq.size() != 0;
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    if (n >= budget) fail_now("drain_timeout", n);
  endtask

  task automatic wait_hs(input int h0);
    int n;
    n = 0;
    while (hs_cnt == h0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (hs_cnt == h0) fail_now("hs_timeout", n);
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b1;
    sbq.delete();
    for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
    mptr = 0;
    @(posedge clk);
    #1;
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    while (!bus.init_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_latency", 32'(n), 32'd16);
  endtask

  initial begin
    int h;
    logic [DW-1:0] pd;
    do_reset();

    // Zero-fill: every address reads 0.
    for (int a = 0; a < DEPTH; a++) push(a % NREQ, 1'b0, AW'(a), '0);
    wait_drain(400);

    // Write 0xA5 @3 then read it back.
    push(0, 1'b1, 4'h3, 8'hA5);
    push(0, 1'b0, 4'h3, 8'h00);
    wait_drain(100);

    // Write by req3 immediately followed by read by req1.
    h = hs_cnt;
    push(3, 1'b1, 4'hF, 8'h3C);
    wait_hs(h);
    push(1, 1'b0, 4'hF, 8'h00);
    wait_drain(100);

    // One-cycle valid pulse on req2 while req0 is busy.
    h = hs_cnt;
    pd = 8'h77;
    push(0, 1'b0, 4'h2, 8'h00);
    wait_hs(h);
    pulse_txn[2] = '{we: 1'b1, addr: 4'h5, data: pd};
    pulse_req[2] = 1'b1;
    wait_drain(100);
    push(2, 1'b0, 4'h5, 8'h00);
    wait_drain(100);

    // Reset during a read's wait phase.
    push(0, 1'b1, 4'h3, 8'hA5);
    wait_drain(100);
    h = hs_cnt;
    push(1, 1'b0, 4'h3, 8'h00);
    wait_hs(h);
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();

    // All requesters valid at once: rotation from pointer 0.
    gseq.delete();
    push(0, 1'b0, 4'h3, 8'h00);
    push(1, 1'b0, 4'h1, 8'h00);
    push(2, 1'b0, 4'h2, 8'h00);
    push(3, 1'b0, 4'hF, 8'h00);
    push(0, 1'b0, 4'h0, 8'h00);
    wait_drain(200);
    if (gseq.size() == 5) begin
      chk("order0", 32'(gseq[0]), 32'd0);
      chk("order1", 32'(gseq[1]), 32'd1);
      chk("order2", 32'(gseq[2]), 32'd2);
      chk("order3", 32'(gseq[3]), 32'd3);
      chk("order4", 32'(gseq[4]), 32'd0);
    end else begin
      fail_now("order_len", gseq.size());
    end

    // Random mixed traffic.
    for (int n = 0; n < 48; n++)
      push($urandom_range(0, NREQ - 1), 1'($urandom),
           AW'($urandom), DW'($urandom));
    wait_drain(2000);
    for (int a = 0; a < DEPTH; a++)
      push(a % NREQ, 1'b0, AW'(a), '0);
    wait_drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
